// File: rtl/uart_alu_ctrl_if.sv
// Bundles the rx/tx handshake and ALU operand/result signals of the UART-ALU controller.
// The controller uses the slave view; the driving environment uses the master view.
interface uart_alu_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_tx_done_tick;
  logic               o_timeout;
  logic               o_bad_op;
  logic               o_busy;

  modport master (
    output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
           o_timeout, o_bad_op, o_busy
  );

  modport slave (
    input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
           o_timeout, o_bad_op, o_busy
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode bytes from the UART, runs the ALU, sends the result; tx_start 2 cycles after opcode tick.
// No backpressure: rx bytes arriving while busy are dropped; inter-byte idle beyond TIMEOUT_CYCLES aborts the command.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  uart_alu_ctrl_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [NB_DATA-1:0] OP_ADD = NB_DATA'(8'h20);
  localparam logic [NB_DATA-1:0] OP_SUB = NB_DATA'(8'h22);
  localparam logic [NB_DATA-1:0] OP_AND = NB_DATA'(8'h24);
  localparam logic [NB_DATA-1:0] OP_OR  = NB_DATA'(8'h25);
  localparam logic [NB_DATA-1:0] OP_XOR = NB_DATA'(8'h26);
  localparam logic [NB_DATA-1:0] OP_NOR = NB_DATA'(8'h27);
  localparam logic [NB_DATA-1:0] OP_SRA = NB_DATA'(8'h03);
  localparam logic [NB_DATA-1:0] OP_SRL = NB_DATA'(8'h02);

  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_q, timeout_d;
  logic               bad_op_q, bad_op_d;
  logic               busy_q, busy_d;
  logic               op_valid;

  // Comparing the whole byte also enforces that the bits above the opcode field are zero.
  assign op_valid = bus.i_rx_data inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                          OP_XOR, OP_NOR, OP_SRA, OP_SRL};

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;
    bad_op_d  = 1'b0;

    case (state_q)
      GET_A: begin
        if (bus.i_rx_done_tick) begin
          alu_a_d = bus.i_rx_data;
          state_d = GET_B;
        end
      end
      GET_B, GET_OP: begin
        if (bus.i_rx_done_tick) begin
          if (state_q == GET_B) begin
            alu_b_d = bus.i_rx_data;
            state_d = GET_OP;
          end else if (op_valid) begin
            alu_op_d = bus.i_rx_data[NB_OP-1:0];
            state_d  = EXEC;
          end else begin
            bad_op_d = 1'b1;
            state_d  = GET_A;
          end
        end else if (cnt_q == CNT_TERM) begin
          timeout_d = 1'b1;
          state_d   = GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        tx_data_d = bus.i_alu_result;
        state_d   = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.i_tx_done_tick) state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase

    // Derived from the next state so both outputs come straight from flops.
    tx_start_d = (state_d == SEND);
    busy_d     = (state_d != GET_A);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= GET_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      bad_op_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      bad_op_q   <= bad_op_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_alu_a    = alu_a_q;
  assign bus.o_alu_b    = alu_b_q;
  assign bus.o_alu_op   = alu_op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_bad_op   = bad_op_q;
  assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed commands, expected events queued, a negedge monitor pops and compares.
module tb_uart_alu_ctrl;
  localparam logic [1:0] EV_TX  = 2'd0;
  localparam logic [1:0] EV_BAD = 2'd1;
  localparam logic [1:0] EV_TO  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   tests;
  int   errors;
  ev_t  exp_q[$];

  uart_alu_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU sitting outside the controller, as in the full design.
  always_comb begin
    case (bus.o_alu_op)
      6'h20:   bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
      6'h22:   bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
      6'h24:   bus.i_alu_result = bus.o_alu_a & bus.o_alu_b;
      6'h25:   bus.i_alu_result = bus.o_alu_a | bus.o_alu_b;
      6'h26:   bus.i_alu_result = bus.o_alu_a ^ bus.o_alu_b;
      6'h27:   bus.i_alu_result = ~(bus.o_alu_a | bus.o_alu_b);
      6'h03:   bus.i_alu_result = 8'($signed(bus.o_alu_a) >>> bus.o_alu_b);
      6'h02:   bus.i_alu_result = bus.o_alu_a >> bus.o_alu_b;
      default: bus.i_alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.o_tx_start || bus.o_bad_op || bus.o_timeout)) begin
      ev_t act;
      act.kind = bus.o_tx_start ? EV_TX : (bus.o_bad_op ? EV_BAD : EV_TO);
      act.data = bus.o_tx_start ? bus.o_tx_data : 8'h00;
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(act), 32'hFFFF_FFFF);
      end else begin
        check("scoreboard_event", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge; the tick is sampled by the following posedge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_done_tick = 1'b1;
    bus.i_rx_data      = b;
    @(negedge clk);
    bus.i_rx_done_tick = 1'b0;
  endtask

  task automatic tx_done_pulse();
    bus.i_tx_done_tick = 1'b1;
    @(negedge clk);
    bus.i_tx_done_tick = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [1:0] kind, input logic [7:0] res, input bit stray_rx);
    ev_t e;
    e.kind = kind;
    e.data = (kind == EV_TX) ? res : 8'h00;
    exp_q.push_back(e);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    if (kind == EV_TX) begin
      check("tx_start_at_n1", 32'(bus.o_tx_start), 32'd0);
      check("busy_in_exec", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
      check("tx_start_at_n2", 32'(bus.o_tx_start), 32'd1);
      check("tx_data_at_send", 32'(bus.o_tx_data), 32'(res));
      @(negedge clk);
      check("tx_start_one_cycle", 32'(bus.o_tx_start), 32'd0);
      if (stray_rx) send_byte(8'hAA);
      else @(negedge clk);
      @(negedge clk);
      check("tx_data_held", 32'(bus.o_tx_data), 32'(res));
      check("busy_in_wait_tx", 32'(bus.o_busy), 32'd1);
      tx_done_pulse();
      check("busy_after_done", 32'(bus.o_busy), 32'd0);
    end else begin
      check("busy_after_bad_op", 32'(bus.o_busy), 32'd0);
      check("no_tx_on_bad_op", 32'(bus.o_tx_start), 32'd0);
    end
  endtask

  initial begin
    bit early;
    tests  = 0;
    errors = 0;
    rst    = 1'b1;
    bus.i_rx_done_tick = 1'b0;
    bus.i_rx_data      = 8'h00;
    bus.i_tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_alu_a", 32'(bus.o_alu_a), 32'd0);
    check("reset_alu_b", 32'(bus.o_alu_b), 32'd0);
    check("reset_alu_op", 32'(bus.o_alu_op), 32'd0);
    check("reset_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("reset_flags", {28'd0, bus.o_tx_start, bus.o_timeout, bus.o_bad_op, bus.o_busy}, 32'd0);

    run_cmd(8'h05, 8'h03, 8'h20, EV_TX, 8'h08, 1'b0);
    run_cmd(8'h03, 8'h05, 8'h22, EV_TX, 8'hFE, 1'b0);
    run_cmd(8'hF0, 8'h0F, 8'h27, EV_TX, 8'h00, 1'b0);
    run_cmd(8'h50, 8'h05, 8'h25, EV_TX, 8'h55, 1'b0);
    run_cmd(8'hF0, 8'h0F, 8'h27, EV_TX, 8'h00, 1'b0);
    check("alu_op_before_bad", 32'(bus.o_alu_op), 32'h27);

    run_cmd(8'h05, 8'h03, 8'h21, EV_BAD, 8'h00, 1'b0);
    check("alu_op_kept_21", 32'(bus.o_alu_op), 32'h27);
    run_cmd(8'h05, 8'h03, 8'h60, EV_BAD, 8'h00, 1'b0);
    check("alu_op_kept_60", 32'(bus.o_alu_op), 32'h27);
    run_cmd(8'h0C, 8'h0A, 8'h24, EV_TX, 8'h08, 1'b0);

    // Inter-byte timeout: pulse visible 100 cycles after entering GET_B.
    exp_q.push_back('{kind: EV_TO, data: 8'h00});
    send_byte(8'h11);
    check("alu_a_latched", 32'(bus.o_alu_a), 32'h11);
    early = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      early |= bus.o_timeout;
    end
    check("timeout_not_early", 32'(early), 32'd0);
    @(negedge clk);
    check("timeout_pulse", 32'(bus.o_timeout), 32'd1);
    check("busy_with_timeout", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    check("timeout_one_cycle", 32'(bus.o_timeout), 32'd0);

    // Tick on the terminal cycle wins over the timeout.
    send_byte(8'h11);
    repeat (99) @(negedge clk);
    send_byte(8'h22);
    check("terminal_tick_no_timeout", 32'(bus.o_timeout), 32'd0);
    check("terminal_tick_alu_b", 32'(bus.o_alu_b), 32'h22);
    exp_q.push_back('{kind: EV_TX, data: 8'h33});
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    tx_done_pulse();
    check("busy_after_terminal_cmd", 32'(bus.o_busy), 32'd0);

    run_cmd(8'hC3, 8'h0F, 8'h26, EV_TX, 8'hCC, 1'b1);
    run_cmd(8'h02, 8'h02, 8'h20, EV_TX, 8'h04, 1'b0);

    // Stray tx done tick while collecting bytes must be ignored.
    exp_q.push_back('{kind: EV_TX, data: 8'hC0});
    send_byte(8'h81);
    tx_done_pulse();
    send_byte(8'h01);
    send_byte(8'h03);
    repeat (2) @(negedge clk);
    check("sra_busy_wait_tx", 32'(bus.o_busy), 32'd1);
    tx_done_pulse();

    send_byte(8'h09);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_alu_a", 32'(bus.o_alu_a), 32'd0);
    check("midreset_alu_op", 32'(bus.o_alu_op), 32'd0);
    check("midreset_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("midreset_flags", {28'd0, bus.o_tx_start, bus.o_timeout, bus.o_bad_op, bus.o_busy}, 32'd0);
    run_cmd(8'h07, 8'h01, 8'h02, EV_TX, 8'h03, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencing controller between the UART receiver/transmitter and the ALU in the TP2 UART design. It collects three bytes from the receiver (operand A, operand B, opcode), presents them to the combinational ALU, and returns the one-byte result through the transmitter using the start/done-tick handshake. It sits in `top` between `uart_rx`, `alu`, and `uart_tx`. It also supervises inter-byte timeouts and opcode validity.

## Interface
- `NB_DATA`, 8: UART byte and ALU operand/result width.
- `NB_OP`, 6: ALU opcode width; the low bits of the opcode byte.
- `TIMEOUT_CYCLES`, 500000: idle clock cycles tolerated between bytes of one command (10 ms at 50 MHz).

- `i_clock` in 1: system clock, the same one that feeds the baud-rate generator.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_done_tick` in 1: one-cycle pulse from `uart_rx`; a byte is valid on `i_rx_data`.
- `i_rx_data` in NB_DATA: received byte.
- `o_alu_a` out NB_DATA: registered operand A to the ALU.
- `o_alu_b` out NB_DATA: registered operand B to the ALU.
- `o_alu_op` out NB_OP: registered opcode to the ALU.
- `i_alu_result` in NB_DATA: combinational ALU result.
- `o_tx_start` out 1: one-cycle pulse to `uart_tx` that starts the frame.
- `o_tx_data` out NB_DATA: registered byte to transmit; held stable until `i_tx_done_tick`.
- `i_tx_done_tick` in 1: one-cycle pulse from `uart_tx` when the stop bit completes.
- `o_timeout` out 1: one-cycle pulse when a command is abandoned because of an inter-byte timeout.
- `o_bad_op` out 1: one-cycle pulse when a command is rejected because of an invalid opcode.
- `o_busy` out 1: high in every state except `GET_A`.

## Operation
**States:** `GET_A`, `GET_B`, `GET_OP`, `EXEC`, `SEND`, `WAIT_TX`.
- **Reset:** state `GET_A`. Every output register is 0: `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data`, `o_tx_start`, `o_timeout`, `o_bad_op`, `o_busy`. The timeout counter is 0.
- **GET_A:** on `i_rx_done_tick`, latch `o_alu_a <= i_rx_data` and go to `GET_B`.
- **GET_B:** on `i_rx_done_tick`, latch `o_alu_b` and go to `GET_OP`.
- **GET_OP:** on `i_rx_done_tick`, check the byte:
  - If bits [NB_DATA-1:NB_OP] are all 0 and bits [NB_OP-1:0] are one of ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02: latch `o_alu_op` and go to `EXEC`.
  - Otherwise: pulse `o_bad_op`, leave `o_alu_op` unchanged, and go to `GET_A`.
- **EXEC:** one cycle so the ALU settles on the registered operands. Latch `o_tx_data <= i_alu_result` and go to `SEND`.
- **SEND:** assert `o_tx_start` for exactly this one cycle, then go to `WAIT_TX`.
- **WAIT_TX:** on `i_tx_done_tick`, go to `GET_A`.
- **Timeout:** the counter runs only in `GET_B` and `GET_OP`.
  - It clears on every `i_rx_done_tick` and on every entry to those states.
  - When it reaches TIMEOUT_CYCLES-1 with no tick in that cycle, pulse `o_timeout`, clear the counter, and go to `GET_A`.
  - The counter holds 0 in all other states.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- **Busy-time bytes:** `i_rx_done_tick` in `EXEC`, `SEND` or `WAIT_TX` is ignored. The byte is dropped and no flag is raised.
- **Stray done tick:** `i_tx_done_tick` outside `WAIT_TX` is ignored.
- **Simultaneous events:**
  - Timeout terminal count and `i_rx_done_tick` in the same cycle: the byte wins and there is no timeout.
  - `i_reset` overrides everything.
- **Reset mid-command:** discards any partially received command. The next received byte is treated as operand A.
- **Arithmetic:** all arithmetic happens in the ALU. This block performs no arithmetic except the timeout counter.

## Timing
- All outputs are registered. No output has a combinational path from any input.
- Cycle N is the cycle in which the opcode `i_rx_done_tick` is high:
  - N+1: state is `EXEC`; `o_alu_op` is valid.
  - N+2: state is `SEND`; `o_tx_data` is valid and `o_tx_start` = 1.
  - Latency from the opcode tick to `o_tx_start` is therefore 2 cycles.
- `o_tx_data` is stable from `SEND` through the cycle of `i_tx_done_tick` inclusive.
- `o_timeout` and `o_bad_op` are high for exactly one cycle, the cycle after the triggering condition. `o_busy` already reflects `GET_A` in that same cycle.
- `o_alu_a` and `o_alu_b` update one cycle after their tick and hold until the next command overwrites them.

## Test plan
- **ADD:** bytes 0x05, 0x03, 0x20 -> `o_tx_start` 2 cycles after the third tick with `o_tx_data`=0x08. Then `i_tx_done_tick` -> `GET_A` and `o_busy`=0.
- **SUB wrap-around:** bytes 0x03, 0x05, 0x22 -> `o_tx_data`=0xFE. Follow with bytes 0xF0, 0x0F, 0x27 (NOR) -> 0x00.
- **Bad opcode:** bytes 0x05, 0x03, 0x21, then separately 0x05, 0x03, 0x60 -> one `o_bad_op` pulse each, no `o_tx_start`, `o_alu_op` keeps its previous value, next byte is taken as A.
- **Timeout:** with TIMEOUT_CYCLES=100, send byte 0x11 and no more -> `o_timeout` pulse exactly 100 cycles after entering `GET_B`. A tick landing on the terminal cycle instead advances to `GET_OP` with no pulse.
- **Busy drop:** a rx tick with byte 0xAA during `WAIT_TX` -> ignored; the next command 0x02, 0x02, 0x20 returns 0x04.
- **Reset mid-command:** assert `i_reset` for 1 cycle after byte A -> all outputs 0, state `GET_A`. The full command 0x07, 0x01, 0x02 (SRL) then returns 0x03.
